// File: rtl/factory_test_mem_engine.sv
// Command-driven scratch RAM: pointer set, write, read with registered data,
// and a multi-cycle bulk FILL that writes seed+index into every word.
module factory_test_mem_engine #(
    parameter int unsigned MemDepth     = 16,
    parameter int unsigned MemAddrWidth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ena_i,
    input  logic                    cmd_valid_i,
    input  logic [1:0]              cmd_op_i,
    input  logic [7:0]              cmd_data_i,
    output logic [7:0]              rd_data_o,
    output logic                    rd_valid_o,
    output logic                    busy_o,
    output logic [MemAddrWidth-1:0] ptr_o,
    output logic                    cmd_drop_o
);

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    localparam logic [1:0] OpSetAddr = 2'd0;
    localparam logic [1:0] OpWrite   = 2'd1;
    localparam logic [1:0] OpRead    = 2'd2;
    localparam logic [1:0] OpFill    = 2'd3;

    localparam logic [MemAddrWidth-1:0] LastAddr = MemAddrWidth'(MemDepth - 1);

    state_e                  state_q, state_d;
    logic [MemAddrWidth-1:0] ptr_q, ptr_d;
    logic [MemAddrWidth-1:0] cnt_q, cnt_d;
    logic [7:0]              seed_q, seed_d;
    logic [7:0]              rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    cmd_drop_q, cmd_drop_d;

    logic [7:0]              mem_q [MemDepth];
    logic                    mem_we;
    logic [MemAddrWidth-1:0] mem_waddr;
    logic [7:0]              mem_wdata;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        seed_d     = seed_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        cmd_drop_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q;
        mem_wdata  = cmd_data_i;

        case (state_q)
            StIdle: begin
                if (ena_i && cmd_valid_i) begin
                    case (cmd_op_i)
                        OpSetAddr: ptr_d = cmd_data_i[MemAddrWidth-1:0];
                        OpWrite: begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + 1'b1;
                        end
                        OpRead: begin
                            rd_data_d  = mem_q[ptr_q];
                            rd_valid_d = 1'b1;
                            ptr_d      = ptr_q + 1'b1;
                        end
                        OpFill: begin
                            seed_d  = cmd_data_i;
                            cnt_d   = '0;
                            state_d = StFill;
                        end
                        default: ;
                    endcase
                end
            end
            StFill: begin
                // Commands arriving mid-fill are rejected without touching fill progress.
                if (ena_i) begin
                    cmd_drop_d = cmd_valid_i;
                    mem_we     = 1'b1;
                    mem_waddr  = cnt_q;
                    mem_wdata  = seed_q + 8'(cnt_q);
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == LastAddr) begin
                        state_d = StIdle;
                        ptr_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            seed_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            cmd_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            seed_q     <= seed_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            cmd_drop_q <= cmd_drop_d;
        end
    end

    // RAM is deliberately not reset so a partial fill survives an abort.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = (state_q == StFill);
    assign ptr_o      = ptr_q;
    assign cmd_drop_o = cmd_drop_q;

endmodule
